// File: rtl/ro_puf_resp_gen_if.sv
// rtl/ro_puf_resp_gen_if.sv - host-side bus of the RO PUF response generator
//
// Purpose
//   Groups the request (start/challenge/window) and result (status/response/counts)
//   signals exchanged between the host/readout logic and ro_puf_resp_gen.
//   The host drives through the master modport; the generator uses the slave modport.
//
// Signals
//   start      host -> gen   1          request evaluation, sampled only while idle
//   chal_a     host -> gen   SEL_W      base select for RO A
//   chal_b     host -> gen   SEL_W      base select for RO B
//   win_len    host -> gen   WIN_W      window length in clk cycles (0 acts as 1)
//   busy       gen -> host   1          evaluation in progress
//   done       gen -> host   1          single-cycle end-of-evaluation pulse
//   err        gen -> host   1          single-cycle pulse with done on a degenerate pair
//   resp_valid gen -> host   1          response holds a complete result
//   response   gen -> host   RESP_BITS  response word, bit i from pair i
//   tie        gen -> host   1          some pair produced equal counts
//   cnt_a      gen -> host   CNT_W      last completed count of RO A
//   cnt_b      gen -> host   CNT_W      last completed count of RO B

interface ro_puf_resp_gen_if #(
   parameter int SEL_W     = 4,
   parameter int CNT_W     = 16,
   parameter int WIN_W     = 16,
   parameter int RESP_BITS = 8
);
   logic                 start;
   logic [SEL_W-1:0]     chal_a;
   logic [SEL_W-1:0]     chal_b;
   logic [WIN_W-1:0]     win_len;
   logic                 busy;
   logic                 done;
   logic                 err;
   logic                 resp_valid;
   logic [RESP_BITS-1:0] response;
   logic                 tie;
   logic [CNT_W-1:0]     cnt_a;
   logic [CNT_W-1:0]     cnt_b;

   modport master (
      output start, chal_a, chal_b, win_len,
      input  busy, done, err, resp_valid, response, tie, cnt_a, cnt_b
   );

   modport slave (
      input  start, chal_a, chal_b, win_len,
      output busy, done, err, resp_valid, response, tie, cnt_a, cnt_b
   );
endinterface

// File: rtl/ro_puf_resp_gen.sv
// rtl/ro_puf_resp_gen.sv - multi-bit ring-oscillator PUF response generator
//
// Purpose
//   For each response bit i an RO pair is chosen from the latched challenge
//   (sel = chal + i, wrapping at NUM_RO). Rising edges of both selected oscillators
//   are counted over a window of W clk cycles and the counts are compared:
//   bit i = (cnt_a > cnt_b), equal counts give 0 and raise the sticky tie flag.
//   Per pair: 2 SETUP cycles, W COUNT cycles, 1 COMPARE cycle, so a start sampled
//   in cycle T produces done in cycle T + RESP_BITS*(W+3) + 1.
//
// Ports
//   i_clk     in   1        system clock
//   i_rst_n   in   1        asynchronous reset, active high (1 = in reset)
//   i_osc_in  in   NUM_RO   free-running RO taps, asynchronous to i_clk
//   io_host   slave        host bus (start/challenge/window in, status/response out)

module ro_puf_resp_gen #(
   parameter int NUM_RO    = 16,
   parameter int SEL_W     = 4,
   parameter int CNT_W     = 16,
   parameter int WIN_W     = 16,
   parameter int RESP_BITS = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [NUM_RO-1:0] i_osc_in,
   ro_puf_resp_gen_if.slave  io_host
);

   localparam int               IDX_W    = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESP_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_COUNT,
      S_COMPARE,
      S_DONE
   } state_t;

   state_t               r_state;
   logic                 r_setup_ph;     // 0 = first SETUP cycle, 1 = second
   logic [SEL_W-1:0]     r_chal_a;
   logic [SEL_W-1:0]     r_chal_b;
   logic [WIN_W-1:0]     r_win;          // latched window, never 0
   logic [WIN_W-1:0]     r_wcnt;
   logic [IDX_W-1:0]     r_idx;
   logic [CNT_W-1:0]     r_ca;
   logic [CNT_W-1:0]     r_cb;

   logic                 r_busy;
   logic                 r_done;
   logic                 r_err;
   logic                 r_resp_valid;
   logic [RESP_BITS-1:0] r_resp;
   logic                 r_tie;
   logic [CNT_W-1:0]     r_cnt_a_out;
   logic [CNT_W-1:0]     r_cnt_b_out;

   // Oscillator capture pipelines: meta -> sync -> prev (edge detector history).
   logic                 r_a_meta;
   logic                 r_a_sync;
   logic                 r_a_prev;
   logic                 r_b_meta;
   logic                 r_b_sync;
   logic                 r_b_prev;

   logic [SEL_W-1:0]     w_sel_a;
   logic [SEL_W-1:0]     w_sel_b;
   logic                 w_osc_a;
   logic                 w_osc_b;
   logic                 w_edge_a;
   logic                 w_edge_b;
   logic                 w_setup_last;

   // Pair selection; the SEL_W-bit add wraps naturally modulo NUM_RO.
   assign w_sel_a = r_chal_a + SEL_W'(r_idx);
   assign w_sel_b = r_chal_b + SEL_W'(r_idx);
   assign w_osc_a = i_osc_in[w_sel_a];
   assign w_osc_b = i_osc_in[w_sel_b];

   assign w_setup_last = (r_state == S_SETUP) && r_setup_ph;

   assign w_edge_a = r_a_sync & ~r_a_prev;
   assign w_edge_b = r_b_sync & ~r_b_prev;

   // Two-flop synchronisers behind the selection mux. On the last SETUP cycle the
   // edge history is loaded with the value the sync stage is about to take, so the
   // level of the previously selected oscillator can never show up as a false edge
   // in the first COUNT cycle after a mux change.
   always_ff @(posedge i_clk or posedge i_rst_n) begin
      if (i_rst_n) begin
         r_a_meta <= 1'b0;
         r_a_sync <= 1'b0;
         r_a_prev <= 1'b0;
         r_b_meta <= 1'b0;
         r_b_sync <= 1'b0;
         r_b_prev <= 1'b0;
      end else begin
         r_a_meta <= w_osc_a;
         r_a_sync <= r_a_meta;
         r_a_prev <= w_setup_last ? r_a_meta : r_a_sync;
         r_b_meta <= w_osc_b;
         r_b_sync <= r_b_meta;
         r_b_prev <= w_setup_last ? r_b_meta : r_b_sync;
      end
   end

   // Evaluation sequencer with registered outputs.
   always_ff @(posedge i_clk or posedge i_rst_n) begin
      if (i_rst_n) begin
         r_state      <= S_IDLE;
         r_setup_ph   <= 1'b0;
         r_chal_a     <= '0;
         r_chal_b     <= '0;
         r_win        <= '0;
         r_wcnt       <= '0;
         r_idx        <= '0;
         r_ca         <= '0;
         r_cb         <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp       <= '0;
         r_tie        <= 1'b0;
         r_cnt_a_out  <= '0;
         r_cnt_b_out  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (io_host.start) begin
                  r_chal_a     <= io_host.chal_a;
                  r_chal_b     <= io_host.chal_b;
                  r_win        <= (io_host.win_len == '0) ? WIN_W'(1) : io_host.win_len;
                  r_resp       <= '0;
                  r_resp_valid <= 1'b0;
                  r_tie        <= 1'b0;
                  r_idx        <= '0;
                  r_setup_ph   <= 1'b0;
                  r_busy       <= 1'b1;
                  r_state      <= S_SETUP;
               end
            end

            S_SETUP: begin
               // Edges seen here belong to the flushing pipeline and are dropped.
               r_ca   <= '0;
               r_cb   <= '0;
               r_wcnt <= '0;
               if (!r_setup_ph) begin
                  r_setup_ph <= 1'b1;
               end else begin
                  r_setup_ph <= 1'b0;
                  if (w_sel_a == w_sel_b) begin
                     r_err   <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_COUNT;
                  end
               end
            end

            S_COUNT: begin
               if (w_edge_a && (r_ca != CNT_MAX)) begin
                  r_ca <= r_ca + 1'b1;
               end
               if (w_edge_b && (r_cb != CNT_MAX)) begin
                  r_cb <= r_cb + 1'b1;
               end
               if (r_wcnt == (r_win - 1'b1)) begin
                  r_state <= S_COMPARE;
               end else begin
                  r_wcnt <= r_wcnt + 1'b1;
               end
            end

            S_COMPARE: begin
               r_resp[r_idx] <= (r_ca > r_cb);
               if (r_ca == r_cb) begin
                  r_tie <= 1'b1;
               end
               r_cnt_a_out <= r_ca;
               r_cnt_b_out <= r_cb;
               if (r_idx == LAST_IDX) begin
                  r_done       <= 1'b1;
                  r_resp_valid <= 1'b1;
                  r_state      <= S_DONE;
               end else begin
                  r_idx   <= r_idx + 1'b1;
                  r_state <= S_SETUP;
               end
            end

            S_DONE: begin
               r_done  <= 1'b0;
               r_err   <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_err   <= 1'b0;
            end
         endcase
      end
   end

   assign io_host.busy       = r_busy;
   assign io_host.done       = r_done;
   assign io_host.err        = r_err;
   assign io_host.resp_valid = r_resp_valid;
   assign io_host.response   = r_resp;
   assign io_host.tie        = r_tie;
   assign io_host.cnt_a      = r_cnt_a_out;
   assign io_host.cnt_b      = r_cnt_b_out;

endmodule
